// File: rtl/debounced_logic_gate_n.sv
// N-input debounced logic gate: synchronised, debounced switches feed a mode-selectable
// AND/OR/XOR/NAND gate driving a registered LED, plus a saturating LED toggle counter.
module debounced_logic_gate_n #(
  parameter int unsigned NUM_SWITCHES   = 2,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  input  logic [1:0]              i_Mode,
  output logic [NUM_SWITCHES-1:0] o_Switch_Db,
  output logic                    o_LED_1,
  output logic [COUNT_WIDTH-1:0]  o_Toggle_Count
);

  localparam int unsigned CntW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

  logic [NUM_SWITCHES-1:0] s1_q, s2_q;
  logic [NUM_SWITCHES-1:0] db_q, db_d;
  logic [CntW-1:0]         cnt_q [NUM_SWITCHES];
  logic [CntW-1:0]         cnt_d [NUM_SWITCHES];
  logic                    led_q, led_d;
  logic [COUNT_WIDTH-1:0]  toggle_q, toggle_d;

  // Per-channel debounce: a change is accepted only after DEBOUNCE_LIMIT differing samples.
  always_comb begin
    db_d = db_q;
    for (int k = 0; k < NUM_SWITCHES; k++) begin
      cnt_d[k] = cnt_q[k];
      if (s2_q[k] == db_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CntMax) begin
        db_d[k]  = s2_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    unique case (i_Mode)
      2'b00:   led_d = &db_q;
      2'b01:   led_d = |db_q;
      2'b10:   led_d = ^db_q;
      2'b11:   led_d = ~&db_q;
      default: led_d = 1'b0;
    endcase
  end

  always_comb begin
    toggle_d = toggle_q;
    if ((led_d != led_q) && (toggle_q != '1)) begin
      toggle_d = toggle_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      led_q    <= 1'b0;
      toggle_q <= '0;
      for (int k = 0; k < NUM_SWITCHES; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      s1_q     <= i_Switch;
      s2_q     <= s1_q;
      db_q     <= db_d;
      led_q    <= led_d;
      toggle_q <= toggle_d;
      for (int k = 0; k < NUM_SWITCHES; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign o_Switch_Db    = db_q;
  assign o_LED_1        = led_q;
  assign o_Toggle_Count = toggle_q;

endmodule
